// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter sharing the GPR write port among three writeback sources, with a RAW busy scoreboard.
// Optional write-stage forwarding ports are built when GPR_WB_FORWARD_EN is defined.
`ifndef XLEN
`define XLEN 32
`endif

module gpr_wb_arbiter #(
  parameter int XLEN = `XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        i_req_valid,
  input  logic [14:0]       i_req_addr,
  input  logic [3*XLEN-1:0] i_req_data,
  output logic [2:0]        o_req_ready,
  input  logic              i_issue_flag,
  input  logic [4:0]        i_issue_addr,
  output logic              o_write_flag,
  output logic [4:0]        o_write_addr,
  output logic [XLEN-1:0]   o_write_data,
  output logic [31:0]       o_busy
`ifdef GPR_WB_FORWARD_EN
  ,
  input  logic [4:0]        i_fwd_addr1,
  input  logic [4:0]        i_fwd_addr2,
  output logic              o_fwd_hit1,
  output logic              o_fwd_hit2,
  output logic [XLEN-1:0]   o_fwd_data1,
  output logic [XLEN-1:0]   o_fwd_data2
`endif
);

  logic [1:0]      ptr;
  logic [1:0]      gidx;
  logic [1:0]      cand;
  logic [2:0]      sum;
  logic [2:0]      grant;
  logic            xfer;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;
  logic [31:0]     busy_next;

  // Walk the priority order backwards so the highest-priority valid requester is the last one assigned.
  always_comb begin
    grant = '0;
    gidx  = 2'd0;
    sum   = '0;
    cand  = 2'd0;
    if (rst) begin
      for (int i = 2; i >= 0; i--) begin
        sum = {1'b0, ptr} + 3'(i);
        if (sum >= 3'd3) sum = sum - 3'd3;
        cand = sum[1:0];
        if (i_req_valid[cand]) begin
          grant = 3'b001 << cand;
          gidx  = cand;
        end
      end
    end
  end

  assign o_req_ready = grant;
  assign xfer        = |grant;

  always_comb begin
    case (gidx)
      2'd1:    begin sel_addr = i_req_addr[9:5];   sel_data = i_req_data[2*XLEN-1:XLEN];   end
      2'd2:    begin sel_addr = i_req_addr[14:10]; sel_data = i_req_data[3*XLEN-1:2*XLEN]; end
      default: begin sel_addr = i_req_addr[4:0];   sel_data = i_req_data[XLEN-1:0];        end
    endcase
  end

  // Retiring write clears first so a same-cycle issue to the same register keeps it busy.
  always_comb begin
    busy_next = o_busy;
    if (o_write_flag) busy_next[o_write_addr] = 1'b0;
    if (i_issue_flag) busy_next[i_issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr          <= 2'd0;
      o_write_flag <= 1'b0;
      o_write_addr <= 5'd0;
      o_write_data <= '0;
      o_busy       <= '0;
    end else begin
      o_busy       <= busy_next;
      o_write_flag <= xfer && (sel_addr != 5'd0);
      if (xfer) begin
        ptr <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
        if (sel_addr != 5'd0) begin
          o_write_addr <= sel_addr;
          o_write_data <= sel_data;
        end
      end
    end
  end

`ifdef GPR_WB_FORWARD_EN
  assign o_fwd_hit1  = o_write_flag && (o_write_addr == i_fwd_addr1) && (i_fwd_addr1 != 5'd0);
  assign o_fwd_hit2  = o_write_flag && (o_write_addr == i_fwd_addr2) && (i_fwd_addr2 != 5'd0);
  assign o_fwd_data1 = o_fwd_hit1 ? o_write_data : '0;
  assign o_fwd_data2 = o_fwd_hit2 ? o_write_data : '0;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: expected writes queued at each handshake, compared when they retire.
// Forwarding checks are compiled in when GPR_WB_FORWARD_EN is defined.
module tb_gpr_wb_arbiter;
  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [2:0]        i_req_valid = '0;
  logic [4:0]        a [3];
  logic [XLEN-1:0]   d [3];
  logic [14:0]       i_req_addr;
  logic [3*XLEN-1:0] i_req_data;
  logic [2:0]        o_req_ready;
  logic              i_issue_flag = 1'b0;
  logic [4:0]        i_issue_addr = '0;
  logic              o_write_flag;
  logic [4:0]        o_write_addr;
  logic [XLEN-1:0]   o_write_data;
  logic [31:0]       o_busy;
`ifdef GPR_WB_FORWARD_EN
  logic [4:0]        i_fwd_addr1 = '0;
  logic [4:0]        i_fwd_addr2 = '0;
  logic              o_fwd_hit1, o_fwd_hit2;
  logic [XLEN-1:0]   o_fwd_data1, o_fwd_data2;
`endif

  assign i_req_addr = {a[2], a[1], a[0]};
  assign i_req_data = {d[2], d[1], d[0]};

  gpr_wb_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready),
    .i_issue_flag(i_issue_flag), .i_issue_addr(i_issue_addr),
    .o_write_flag(o_write_flag), .o_write_addr(o_write_addr), .o_write_data(o_write_data),
    .o_busy(o_busy)
`ifdef GPR_WB_FORWARD_EN
    ,
    .i_fwd_addr1(i_fwd_addr1), .i_fwd_addr2(i_fwd_addr2),
    .o_fwd_hit1(o_fwd_hit1), .o_fwd_hit2(o_fwd_hit2),
    .o_fwd_data1(o_fwd_data1), .o_fwd_data2(o_fwd_data2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } wb_t;

  wb_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ptr_m  = 0;
  logic mon_en = 1'b0;

  function automatic logic [2:0] exp_grant(input logic [2:0] v, input int p);
    for (int i = 0; i < 3; i++) begin
      int k;
      k = (p + i) % 3;
      if (v[k]) return 3'(1 << k);
    end
    return 3'b000;
  endfunction

  // Called right after the posedge on which grant g was taken.
  task automatic commit(input logic [2:0] g);
    wb_t e;
    for (int k = 0; k < 3; k++) begin
      if (g[k]) begin
        if (a[k] != 5'd0) begin
          e.addr = a[k];
          e.data = d[k];
          exp_q.push_back(e);
        end
        ptr_m = (k + 1) % 3;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_req_valid  = '0;
      i_issue_flag = 1'b0;
    end
  endtask

  // Every retiring write must match the oldest queued handshake, and every queued handshake must retire.
  always @(negedge clk) begin
    wb_t e;
    if (mon_en && (o_write_flag === 1'b1 || exp_q.size() > 0)) begin
      checks++;
      if (o_write_flag !== 1'b1) begin
        errors++;
        e = exp_q.pop_front();
        $display("FAIL wb_missing: write_flag %b, want write addr %0d data %h", o_write_flag, e.addr, e.data);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: write addr %0d data %h, want no write", o_write_addr, o_write_data);
      end else begin
        e = exp_q.pop_front();
        if (o_write_addr !== e.addr || o_write_data !== e.data) begin
          errors++;
          $display("FAIL wb_payload: got addr %0d data %h, want addr %0d data %h",
                   o_write_addr, o_write_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    i_req_valid = 3'b111;
    a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
    d[0] = 32'h1; d[1] = 32'h2; d[2] = 32'h3;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      #1;
      checks++;
      if (o_req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b want 000", o_req_ready); end
      checks++;
      if (o_write_flag !== 1'b0 || o_write_addr !== 5'd0 || o_write_data !== '0) begin
        errors++;
        $display("FAIL reset_out: got flag %b addr %0d data %h want 0/0/0", o_write_flag, o_write_addr, o_write_data);
      end
      checks++;
      if (o_busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", o_busy); end
    end
    @(negedge clk);
    rst = 1'b1;
    i_req_valid = '0;
    ptr_m = 0;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    a[1] = 5'd5;
    d[1] = 32'hDEADBEEF;
    i_req_valid = 3'b010;
    #1;
    checks++;
    if (o_req_ready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b want 010", o_req_ready); end
    @(posedge clk);
    commit(3'b010);
    @(negedge clk);
    i_req_valid = '0;
    #1;
    checks++;
    if (o_write_flag !== 1'b1 || o_write_addr !== 5'd5 || o_write_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_out: got flag %b addr %0d data %h want 1/5/deadbeef", o_write_flag, o_write_addr, o_write_data);
    end
    idle(1);
  endtask

  task automatic test_round_robin();
    int   seq [6] = '{0, 1, 2, 0, 1, 2};
    logic [2:0] want;
    @(negedge clk);
    rst = 1'b0;
    i_req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    ptr_m = 0;
    a[0] = 5'd1; a[1] = 5'd9; a[2] = 5'd17;
    d[0] = $urandom; d[1] = $urandom; d[2] = $urandom;
    for (int n = 0; n < 6; n++) begin
      if (n > 0) @(negedge clk);
      if (n > 0) begin
        a[seq[n-1]] = 5'(seq[n-1] * 8 + n + 2);
        d[seq[n-1]] = $urandom;
      end
      i_req_valid = 3'b111;
      #1;
      want = 3'b001 << seq[n];
      checks++;
      if (o_req_ready !== want) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", n, o_req_ready, want); end
      if (n > 0) begin
        checks++;
        if (o_write_flag !== 1'b1) begin errors++; $display("FAIL rr_b2b%0d: write_flag %b want 1", n, o_write_flag); end
      end
      @(posedge clk);
      commit(want);
    end
    @(negedge clk);
    i_req_valid = '0;
    #1;
    checks++;
    if (o_write_flag !== 1'b1) begin errors++; $display("FAIL rr_last: write_flag %b want 1", o_write_flag); end
    idle(1);
  endtask

  task automatic test_scoreboard();
    logic [2:0] g;
    @(negedge clk);
    i_issue_flag = 1'b1; i_issue_addr = 5'd7;
    @(negedge clk);
    i_issue_addr = 5'd31;
    #1;
    checks++;
    if (o_busy !== 32'h0000_0080) begin errors++; $display("FAIL sb_set7: busy %h want 00000080", o_busy); end
    @(negedge clk);
    i_issue_flag = 1'b0;
    a[0] = 5'd7; d[0] = 32'h0707_0707;
    i_req_valid = 3'b001;
    #1;
    checks++;
    if (o_busy !== 32'h8000_0080) begin errors++; $display("FAIL sb_set31: busy %h want 80000080", o_busy); end
    g = exp_grant(3'b001, ptr_m);
    checks++;
    if (o_req_ready !== g) begin errors++; $display("FAIL sb_ready_a: got %b want %b", o_req_ready, g); end
    @(posedge clk);
    commit(g);
    @(negedge clk);
    i_req_valid = '0;
    #1;
    checks++;
    if (o_busy !== 32'h8000_0080) begin errors++; $display("FAIL sb_hold_during_wb: busy %h want 80000080", o_busy); end
    @(negedge clk);
    #1;
    checks++;
    if (o_busy !== 32'h8000_0000) begin errors++; $display("FAIL sb_clear7: busy %h want 80000000", o_busy); end
    // Re-issue 7 so the next retirement of 7 collides with a new issue of 7.
    i_issue_flag = 1'b1; i_issue_addr = 5'd7;
    @(negedge clk);
    i_issue_flag = 1'b0;
    d[0] = 32'h7777_0000;
    i_req_valid = 3'b001;
    #1;
    g = exp_grant(3'b001, ptr_m);
    checks++;
    if (o_req_ready !== g) begin errors++; $display("FAIL sb_ready_b: got %b want %b", o_req_ready, g); end
    @(posedge clk);
    commit(g);
    @(negedge clk);
    i_req_valid = '0;
    i_issue_flag = 1'b1; i_issue_addr = 5'd7;
    @(negedge clk);
    i_issue_flag = 1'b0;
    #1;
    checks++;
    if (o_busy !== 32'h8000_0080) begin errors++; $display("FAIL sb_set_wins: busy %h want 80000080", o_busy); end
    a[1] = 5'd7;  d[1] = 32'h1111_0007;
    a[2] = 5'd31; d[2] = 32'h2222_001F;
    i_req_valid = 3'b110;
    #1;
    g = exp_grant(3'b110, ptr_m);
    checks++;
    if (o_req_ready !== g) begin errors++; $display("FAIL sb_ready_c: got %b want %b", o_req_ready, g); end
    @(posedge clk);
    commit(g);
    @(negedge clk);
    i_req_valid = 3'b110 & ~g;
    #1;
    g = exp_grant(i_req_valid, ptr_m);
    checks++;
    if (o_req_ready !== g) begin errors++; $display("FAIL sb_ready_d: got %b want %b", o_req_ready, g); end
    @(posedge clk);
    commit(g);
    idle(2);
    #1;
    checks++;
    if (o_busy !== 32'h0) begin errors++; $display("FAIL sb_drain: busy %h want 0", o_busy); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    a[1] = 5'd12; d[1] = 32'h0C0C_0C0C;
    i_req_valid = 3'b010;
    #1;
    checks++;
    if (o_req_ready !== 3'b010) begin errors++; $display("FAIL x0_pre_ready: got %b want 010", o_req_ready); end
    @(posedge clk);
    commit(3'b010);
    @(negedge clk);
    a[2] = 5'd0; d[2] = 32'hBAD0_BAD0;
    i_req_valid = 3'b100;
    #1;
    checks++;
    if (o_req_ready !== 3'b100) begin errors++; $display("FAIL x0_ready: got %b want 100", o_req_ready); end
    @(posedge clk);
    commit(3'b100);
    @(negedge clk);
    a[0] = 5'd4; a[1] = 5'd13; a[2] = 5'd14;
    i_req_valid = 3'b111;
    i_issue_flag = 1'b1; i_issue_addr = 5'd0;
    #1;
    checks++;
    if (o_req_ready !== 3'b001) begin errors++; $display("FAIL x0_ptr: got %b want 001", o_req_ready); end
    checks++;
    if (o_write_flag !== 1'b0 || o_write_addr !== 5'd12) begin
      errors++;
      $display("FAIL x0_out: got flag %b addr %0d want 0/12", o_write_flag, o_write_addr);
    end
    @(posedge clk);
    commit(3'b001);
    @(negedge clk);
    i_req_valid = '0;
    i_issue_flag = 1'b0;
    #1;
    checks++;
    if (o_busy !== 32'h0) begin errors++; $display("FAIL x0_busy: busy %h want 0", o_busy); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    logic [2:0] g;
    @(negedge clk);
    a[0] = 5'd20; a[1] = 5'd21; a[2] = 5'd22;
    i_req_valid = 3'b111;
    i_issue_flag = 1'b1; i_issue_addr = 5'd9;
    #1;
    g = exp_grant(3'b111, ptr_m);
    checks++;
    if (o_req_ready !== g) begin errors++; $display("FAIL rm_ready: got %b want %b", o_req_ready, g); end
    @(posedge clk);
    commit(g);
    @(negedge clk);
    i_issue_flag = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (o_req_ready !== 3'b000) begin errors++; $display("FAIL rm_ready_in_rst: got %b want 000", o_req_ready); end
    @(negedge clk);
    #1;
    checks++;
    if (o_write_flag !== 1'b0 || o_write_addr !== 5'd0 || o_write_data !== '0 || o_busy !== 32'h0) begin
      errors++;
      $display("FAIL rm_cleared: got flag %b addr %0d data %h busy %h want all 0",
               o_write_flag, o_write_addr, o_write_data, o_busy);
    end
    rst = 1'b1;
    ptr_m = 0;
    #1;
    checks++;
    if (o_req_ready !== 3'b001) begin errors++; $display("FAIL rm_ptr: got %b want 001", o_req_ready); end
    @(posedge clk);
    commit(3'b001);
    idle(2);
  endtask

`ifdef GPR_WB_FORWARD_EN
  task automatic test_forward();
    @(negedge clk);
    a[0] = 5'd3; d[0] = 32'hCAFE_0003;
    i_req_valid = 3'b001;
    i_fwd_addr1 = 5'd3; i_fwd_addr2 = 5'd0;
    #1;
    checks++;
    if (o_fwd_hit1 !== 1'b0) begin errors++; $display("FAIL fwd_idle: hit1 %b want 0", o_fwd_hit1); end
    @(posedge clk);
    commit(exp_grant(3'b001, ptr_m));
    @(negedge clk);
    i_req_valid = '0;
    #1;
    checks++;
    if (o_fwd_hit1 !== 1'b1 || o_fwd_data1 !== 32'hCAFE_0003) begin
      errors++;
      $display("FAIL fwd_hit1: got hit %b data %h want 1/cafe0003", o_fwd_hit1, o_fwd_data1);
    end
    checks++;
    if (o_fwd_hit2 !== 1'b0 || o_fwd_data2 !== '0) begin
      errors++;
      $display("FAIL fwd_x0: got hit %b data %h want 0/0", o_fwd_hit2, o_fwd_data2);
    end
    idle(2);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_scoreboard();
    test_x0();
    test_reset_mid();
`ifdef GPR_WB_FORWARD_EN
    test_forward();
`endif
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL wb_drain: %0d writes never retired, want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the general register file's single write port among three writeback requesters: req0 ALU, req1 load unit, req2 CSR/multiplier.
- Uses round-robin arbitration with a valid/ready handshake.
- Drives the register file write port from a registered output stage.
- Keeps a 32-entry busy scoreboard so issue logic can detect RAW hazards on pending destination registers.

Parameters:
- XLEN, 32, datapath width; must equal the global `XLEN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low (asserted when rst==0).
- i_req_valid  in  3  per-requester writeback valid; bit k = requester k.
- i_req_addr  in  15  flat destination addresses; bits [5k+4:5k] = requester k.
- i_req_data  in  3*XLEN  flat write data; bits [XLEN*k+XLEN-1:XLEN*k] = requester k.
- o_req_ready  out  3  per-requester grant (combinational); one-hot or zero.
- i_issue_flag  in  1  instruction issued with a destination register.
- i_issue_addr  in  5  destination of the issued instruction.
- o_write_flag  out  1  to register file i_write_flag (`WRITE_ENABLE = 1).
- o_write_addr  out  5  to register file i_write_addr.
- o_write_data  out  XLEN  to register file i_write_data.
- o_busy  out  32  scoreboard; bit r = register xr has a pending write.

Behaviour:
- Reset (rst==0 at posedge):
  - o_write_flag=0, o_write_addr=0, o_write_data=0, o_busy=0.
  - Round-robin pointer = 0 (req0 highest priority).
  - o_req_ready is 0 while rst==0.
- Arbitration (combinational):
  - Priority order is ptr, ptr+1, ptr+2 (mod 3).
  - The first requester in that order with i_req_valid=1 gets o_req_ready=1; at most one grant per cycle.
- Handshake:
  - A transfer occurs when valid & ready on the same cycle.
  - The requester holds valid, addr and data stable until granted.
  - Valid may drop only after a transfer.
- Pointer update:
  - After a transfer by requester k, ptr <= (k+1) mod 3.
  - With no transfer, ptr holds.
- Output stage (1-cycle latency):
  - On a transfer, the next cycle has o_write_flag=1 and o_write_addr/o_write_data equal to the granted payload.
  - With no transfer, o_write_flag=0 and addr/data hold their previous values.
  - The register file accepts a write every cycle, so the arbiter never back-pressures on the output side.
- x0 requests:
  - A request with addr 0 is accepted (ready asserted and the pointer advances as normal).
  - It produces o_write_flag=0 and does not touch the scoreboard.
- Scoreboard:
  - set: i_issue_flag=1 with i_issue_addr!=0 sets busy[i_issue_addr] at posedge.
  - clear: a write leaving the output stage (o_write_flag=1) clears busy[o_write_addr] at the same posedge.
  - Set and clear on the same register in the same cycle: set wins (busy stays 1).
  - busy[0] is always 0.
  - Clearing an already-clear bit is harmless.
- Reset mid-operation:
  - Pending grants are discarded, the output stage is cleared and the scoreboard is cleared.
  - Requesters must re-present after reset.

Optional Feature:
- Macro: GPR_WB_FORWARD_EN.
- Defined: adds ports i_fwd_addr1/i_fwd_addr2 (in, 5 each), o_fwd_hit1/o_fwd_hit2 (out, 1 each) and o_fwd_data1/o_fwd_data2 (out, XLEN each).
  - o_fwd_hitN = o_write_flag & (o_write_addr == i_fwd_addrN) & (i_fwd_addrN != 0), combinational.
  - o_fwd_dataN = o_write_data when hit, else 0.
  - This covers the cycle in which the synchronous-read register file would still return stale data.
- Not defined: none of these ports exist and there is no forwarding logic.

Test Plan:
- Reset: hold rst=0 for 2 cycles with all valids=1 -> ready=000, o_write_flag=0, o_busy=0.
- Single request: req1 valid with addr=5, data=0xDEADBEEF -> ready=010 that cycle; next cycle o_write_flag=1, addr=5, data=0xDEADBEEF.
- Round-robin: all three requesters valid continuously from reset -> grants in order 0,1,2,0,1,2, one per cycle, with back-to-back o_write_flag=1.
- Scoreboard set and clear:
  - Issue addr=7 -> busy[7]=1 next cycle.
  - A later req0 write to 7 -> busy[7] returns to 0 on the cycle after o_write_flag=1 with addr=7.
  - Issue 7 on the same cycle the write to 7 retires -> busy[7] stays 1.
- x0 request: req2 valid with addr=0 -> ready asserted and ptr advances to 0; o_write_flag stays 0; issue addr=0 leaves o_busy=0.
- Forwarding (GPR_WB_FORWARD_EN): a write to x3 is in the output stage and i_fwd_addr1=3 -> o_fwd_hit1=1 and o_fwd_data1 equals the write data; i_fwd_addr2=0 -> o_fwd_hit2=0.
